// File: rtl/fetch_ctrl_pkg.sv
// Shared definitions for the instruction-fetch controller: FSM state encoding,
// default reset PC and PC alignment helper.
package fetch_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_DRAIN = 2'd1,
        ST_HALT  = 2'd2
    } fetch_state_e;

    localparam logic [15:0] DEFAULT_RESET_PC = 16'h0000;
    localparam logic [15:0] PC_STEP          = 16'h0002;

    // Instructions are halfword aligned; bit 0 of any redirect is discarded.
    function automatic logic [15:0] align_pc(input logic [15:0] addr);
        return {addr[15:1], 1'b0};
    endfunction

endpackage

// File: rtl/fetch_ctrl_add_16b.sv
// 16-bit modulo adder used for the PC+2 increment.
module add_16b (
    input  logic [15:0] a_i,
    input  logic [15:0] b_i,
    output logic [15:0] y_o
);

    assign y_o = a_i + b_i;

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch controller: owns the PC, fills IF/ID, handles stalls,
// redirects and halt. Optional perf counters under FETCH_PERF_CNT_EN.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter logic [15:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [15:0] branch_target,
    input  logic        hlt_id,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_valid,
    input  logic [15:0] imem_data,
    output logic [15:0] ifid_instr,
    output logic [15:0] ifid_pc2,
    output logic        ifid_valid,
    output logic        flush_ifid,
    output logic        halted
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [15:0] fetch_cnt,
    output logic [15:0] flush_cnt
`endif
);

    fetch_state_e state_q, state_d;
    logic [15:0]  pc_q, pc_d;
    logic [15:0]  tgt_q, tgt_d;
    logic [15:0]  instr_q, instr_d;
    logic [15:0]  pc2_q, pc2_d;
    logic         ivalid_q, ivalid_d;
    logic         flush_q, flush_d;
    logic         halted_q, halted_d;

    logic [15:0]  pc_plus2;
    logic [15:0]  redirect_pc;
    logic         accept;
    logic         redirect;

    add_16b u_pc_inc (
        .a_i (pc_q),
        .b_i (PC_STEP),
        .y_o (pc_plus2)
    );

    assign redirect_pc = align_pc(branch_target);

    // Request is combinational from state so it drops with rst asserted.
    assign imem_req  = (state_q != ST_HALT) && !rst;
    assign imem_addr = pc_q;

    assign ifid_instr = instr_q;
    assign ifid_pc2   = pc2_q;
    assign ifid_valid = ivalid_q;
    assign flush_ifid = flush_q;
    assign halted     = halted_q;

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        tgt_d    = tgt_q;
        instr_d  = instr_q;
        pc2_d    = pc2_q;
        ivalid_d = ivalid_q;
        flush_d  = 1'b0;
        halted_d = halted_q;
        accept   = 1'b0;
        redirect = 1'b0;

        case (state_q)
            ST_FETCH: begin
                if (!stall) begin
                    if (hlt_id) begin
                        state_d  = ST_HALT;
                        ivalid_d = 1'b0;
                        halted_d = 1'b1;
                    end else if (branch_taken) begin
                        redirect = 1'b1;
                        ivalid_d = 1'b0;
                        flush_d  = 1'b1;
                        if (imem_valid) begin
                            pc_d = redirect_pc;
                        end else begin
                            // Request in flight: address must stay put until it completes.
                            tgt_d   = redirect_pc;
                            state_d = ST_DRAIN;
                        end
                    end else if (imem_valid) begin
                        accept   = 1'b1;
                        instr_d  = imem_data;
                        pc2_d    = pc_plus2;
                        ivalid_d = 1'b1;
                        pc_d     = pc_plus2;
                    end else begin
                        ivalid_d = 1'b0;
                    end
                end
            end

            ST_DRAIN: begin
                if (!stall) begin
                    if (hlt_id) begin
                        state_d  = ST_HALT;
                        ivalid_d = 1'b0;
                        halted_d = 1'b1;
                    end else begin
                        if (branch_taken) begin
                            redirect = 1'b1;
                            tgt_d    = redirect_pc;
                            ivalid_d = 1'b0;
                            flush_d  = 1'b1;
                        end
                        if (imem_valid) begin
                            pc_d    = tgt_d;
                            state_d = ST_FETCH;
                        end
                    end
                end
            end

            ST_HALT: begin
                state_d = ST_HALT;
            end

            default: begin
                state_d = ST_FETCH;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_FETCH;
            pc_q     <= align_pc(RESET_PC);
            tgt_q    <= '0;
            instr_q  <= '0;
            pc2_q    <= '0;
            ivalid_q <= 1'b0;
            flush_q  <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            tgt_q    <= tgt_d;
            instr_q  <= instr_d;
            pc2_q    <= pc2_d;
            ivalid_q <= ivalid_d;
            flush_q  <= flush_d;
            halted_q <= halted_d;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [15:0] fetch_cnt_q, fetch_cnt_d;
    logic [15:0] flush_cnt_q, flush_cnt_d;

    // Counters saturate; accept/redirect never fire in HALT so they freeze there.
    always_comb begin
        fetch_cnt_d = fetch_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (accept && (fetch_cnt_q != '1)) begin
            fetch_cnt_d = fetch_cnt_q + 16'd1;
        end
        if (redirect && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign fetch_cnt = fetch_cnt_q;
    assign flush_cnt = flush_cnt_q;
`else
    logic unused_perf;
    assign unused_perf = accept ^ redirect;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: reset, streaming fetch, stall, redirect,
// miss+redirect drain, halt, and PC wrap.
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        branch_taken;
    logic [15:0] branch_target;
    logic        hlt_id;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_valid;
    logic [15:0] imem_data;
    logic [15:0] ifid_instr;
    logic [15:0] ifid_pc2;
    logic        ifid_valid;
    logic        flush_ifid;
    logic        halted;
`ifdef FETCH_PERF_CNT_EN
    logic [15:0] fetch_cnt;
    logic [15:0] flush_cnt;
`endif

    logic zw;
    logic miss_valid;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    // Memory returns 16'hA000 + address; valid either every cycle or on demand.
    assign imem_valid = zw | miss_valid;
    assign imem_data  = 16'hA000 + imem_addr;

    fetch_ctrl #(.RESET_PC(16'h0000)) dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .hlt_id        (hlt_id),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_valid    (imem_valid),
        .imem_data     (imem_data),
        .ifid_instr    (ifid_instr),
        .ifid_pc2      (ifid_pc2),
        .ifid_valid    (ifid_valid),
        .flush_ifid    (flush_ifid),
        .halted        (halted)
`ifdef FETCH_PERF_CNT_EN
        ,
        .fetch_cnt     (fetch_cnt),
        .flush_cnt     (flush_cnt)
`endif
    );

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = '0;
        hlt_id = 1'b0; zw = 1'b0; miss_valid = 1'b0;
        step(); step();
        check("rst_req",    {15'd0, imem_req},   16'h0000);
        check("rst_addr",   imem_addr,           16'h0000);
        check("rst_instr",  ifid_instr,          16'h0000);
        check("rst_pc2",    ifid_pc2,            16'h0000);
        check("rst_valid",  {15'd0, ifid_valid}, 16'h0000);
        check("rst_flush",  {15'd0, flush_ifid}, 16'h0000);
        check("rst_halted", {15'd0, halted},     16'h0000);

        // Zero-wait streaming fetch.
        zw = 1'b1; rst = 1'b0;
        #1;
        check("c1_req",   {15'd0, imem_req},   16'h0001);
        check("c1_addr",  imem_addr,           16'h0000);
        check("c1_valid", {15'd0, ifid_valid}, 16'h0000);
        step();
        check("c2_addr",  imem_addr,           16'h0002);
        check("c2_pc2",   ifid_pc2,            16'h0002);
        check("c2_instr", ifid_instr,          16'hA000);
        check("c2_valid", {15'd0, ifid_valid}, 16'h0001);
        step();
        check("c3_addr",  imem_addr,  16'h0004);
        check("c3_pc2",   ifid_pc2,   16'h0004);
        check("c3_instr", ifid_instr, 16'hA002);

        // Three stall cycles at pc=4; a branch during stall must be ignored.
        stall = 1'b1;
        for (int unsigned i = 0; i < 3; i++) begin
            branch_taken  = (i == 1);
            branch_target = 16'h0040;
            step();
            check("stl_addr",  imem_addr,           16'h0004);
            check("stl_pc2",   ifid_pc2,            16'h0004);
            check("stl_instr", ifid_instr,          16'hA002);
            check("stl_flush", {15'd0, flush_ifid}, 16'h0000);
        end
        stall = 1'b0; branch_taken = 1'b0;
        step();
        check("res_addr",  imem_addr,  16'h0006);
        check("res_pc2",   ifid_pc2,   16'h0006);
        check("res_instr", ifid_instr, 16'hA004);
        step();
        check("pc8_addr",  imem_addr,  16'h0008);

        // Redirect with zero-wait memory, odd target.
        branch_taken = 1'b1; branch_target = 16'h0031;
        step();
        branch_taken = 1'b0;
        check("br_addr",  imem_addr,           16'h0030);
        check("br_flush", {15'd0, flush_ifid}, 16'h0001);
        check("br_valid", {15'd0, ifid_valid}, 16'h0000);
        step();
        check("br2_flush", {15'd0, flush_ifid}, 16'h0000);
        check("br2_valid", {15'd0, ifid_valid}, 16'h0001);
        check("br2_instr", ifid_instr,          16'hA030);
        check("br2_pc2",   ifid_pc2,            16'h0032);
        check("br2_addr",  imem_addr,           16'h0032);

        // Miss: valid arrives in the 4th request cycle; redirect in cycle 1.
        zw = 1'b0;
        branch_taken = 1'b1; branch_target = 16'h0100;
        step();
        branch_taken = 1'b0;
        check("dr1_addr",  imem_addr,           16'h0032);
        check("dr1_flush", {15'd0, flush_ifid}, 16'h0001);
        check("dr1_valid", {15'd0, ifid_valid}, 16'h0000);
        step();
        check("dr2_addr",  imem_addr,           16'h0032);
        check("dr2_req",   {15'd0, imem_req},   16'h0001);
        check("dr2_flush", {15'd0, flush_ifid}, 16'h0000);
        step();
        check("dr3_addr",  imem_addr,           16'h0032);
        miss_valid = 1'b1;
        step();
        miss_valid = 1'b0;
        check("dr4_addr",  imem_addr,           16'h0100);
        check("dr4_valid", {15'd0, ifid_valid}, 16'h0000);
        check("dr4_instr", ifid_instr,          16'hA030);
        zw = 1'b1;
        step();
        check("dr5_instr", ifid_instr, 16'hA100);
        check("dr5_pc2",   ifid_pc2,   16'h0102);
        check("dr5_addr",  imem_addr,  16'h0102);

        // Halt at pc=0x0010; branches afterwards must not wake it.
        branch_taken = 1'b1; branch_target = 16'h0010;
        step();
        branch_taken = 1'b0;
        check("h0_addr", imem_addr, 16'h0010);
        hlt_id = 1'b1;
        step();
        hlt_id = 1'b0;
        check("h_halted", {15'd0, halted},     16'h0001);
        check("h_req",    {15'd0, imem_req},   16'h0000);
        check("h_valid",  {15'd0, ifid_valid}, 16'h0000);
        for (int unsigned i = 0; i < 20; i++) begin
            branch_taken  = (i == 5);
            branch_target = 16'h0200;
            step();
            check("h_addr",   imem_addr,           16'h0010);
            check("h_req_n",  {15'd0, imem_req},   16'h0000);
            check("h_hold",   {15'd0, halted},     16'h0001);
            check("h_flush",  {15'd0, flush_ifid}, 16'h0000);
        end
        branch_taken = 1'b0;
        rst = 1'b1;
        #1;
        check("hr_halted", {15'd0, halted},   16'h0000);
        check("hr_addr",   imem_addr,         16'h0000);
        check("hr_req",    {15'd0, imem_req}, 16'h0000);
        step();
        rst = 1'b0;
        #1;
        check("hr_req1", {15'd0, imem_req}, 16'h0001);

        // PC wrap at 0xFFFE.
        branch_taken = 1'b1; branch_target = 16'hFFFE;
        step();
        branch_taken = 1'b0;
        check("w_addr0", imem_addr, 16'hFFFE);
        step();
        check("w_addr",  imem_addr,           16'h0000);
        check("w_pc2",   ifid_pc2,            16'h0000);
        check("w_instr", ifid_instr,          16'h9FFE);
        check("w_valid", {15'd0, ifid_valid}, 16'h0001);
`ifdef FETCH_PERF_CNT_EN
        check("w_fcnt", fetch_cnt, 16'h0001);
        check("w_xcnt", flush_cnt, 16'h0001);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
